// File: rtl/skin_detect_if.sv
// Video stream bundle: line/frame sync, data enable and pixel data of width DW.
// The master drives the stream and the slave receives it.
interface skin_detect_if #(
    parameter int unsigned DW = 16
);
    logic          hsync;
    logic          vsync;
    logic          de;
    logic [DW-1:0] data;

    modport master (output hsync, vsync, de, data);
    modport slave  (input  hsync, vsync, de, data);
endinterface

// File: rtl/skin_detect.sv
// RGB565 -> YCbCr skin-colour threshold with a 3-clk pipeline.
// Emits a binary mask stream plus a source copy that is aligned to the mask.
module skin_detect #(
    parameter logic [7:0] CB_MIN = 8'd77,
    parameter logic [7:0] CB_MAX = 8'd127,
    parameter logic [7:0] CR_MIN = 8'd133,
    parameter logic [7:0] CR_MAX = 8'd173,
    parameter logic [7:0] Y_MIN  = 8'd40
) (
    input  logic          clk,
    input  logic          rst_n,
    skin_detect_if.slave  i_src,
    skin_detect_if.master o_rgb,
    skin_detect_if.master o_face
);
    typedef struct packed {
        logic        hsync;
        logic        vsync;
        logic        de;
        logic [15:0] data;
    } beat_t;

    beat_t       w_in;
    logic [7:0]  w_r8, w_g8, w_b8;
    beat_t       r_dly [3];
    logic [15:0] r_prod [9];
    logic [15:0] r_ysum, r_cbsum, r_crsum;
    logic [7:0]  r_face;
    logic        w_skin;

    assign w_in = {i_src.hsync, i_src.vsync, i_src.de, i_src.data};
    assign w_r8 = {i_src.data[15:11], i_src.data[15:13]};
    assign w_g8 = {i_src.data[10:5],  i_src.data[10:9]};
    assign w_b8 = {i_src.data[4:0],   i_src.data[4:2]};

    // Thresholds are applied to the full sums: comparing S against {T,8'h00} or
    // {T,8'hff} is the same as comparing S[15:8] against T.
    always_comb begin
        w_skin = r_dly[1].de
              && (r_ysum  >= {Y_MIN,  8'h00})
              && (r_cbsum >= {CB_MIN, 8'h00}) && (r_cbsum <= {CB_MAX, 8'hff})
              && (r_crsum >= {CR_MIN, 8'h00}) && (r_crsum <= {CR_MAX, 8'hff});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 3; i++) r_dly[i] <= '0;
            for (int unsigned i = 0; i < 9; i++) r_prod[i] <= '0;
            r_ysum  <= '0;
            r_cbsum <= '0;
            r_crsum <= '0;
            r_face  <= '0;
        end else begin
            r_dly[0] <= w_in;
            r_dly[1] <= r_dly[0];
            r_dly[2] <= r_dly[1];

            r_prod[0] <= {8'd0, w_r8} * 16'd77;
            r_prod[1] <= {8'd0, w_g8} * 16'd150;
            r_prod[2] <= {8'd0, w_b8} * 16'd29;
            r_prod[3] <= {8'd0, w_r8} * 16'd43;
            r_prod[4] <= {8'd0, w_g8} * 16'd85;
            r_prod[5] <= {8'd0, w_b8} * 16'd128;
            r_prod[6] <= {8'd0, w_r8} * 16'd128;
            r_prod[7] <= {8'd0, w_g8} * 16'd107;
            r_prod[8] <= {8'd0, w_b8} * 16'd21;

            // Positive terms first keeps every intermediate inside 16 bits.
            r_ysum  <= r_prod[0] + r_prod[1] + r_prod[2];
            r_cbsum <= (r_prod[5] + 16'd32768) - r_prod[3] - r_prod[4];
            r_crsum <= (r_prod[6] + 16'd32768) - r_prod[7] - r_prod[8];

            r_face <= w_skin ? 8'hff : 8'h00;
        end
    end

    assign o_rgb.hsync  = r_dly[2].hsync;
    assign o_rgb.vsync  = r_dly[2].vsync;
    assign o_rgb.de     = r_dly[2].de;
    assign o_rgb.data   = r_dly[2].data;
    assign o_face.hsync = r_dly[2].hsync;
    assign o_face.vsync = r_dly[2].vsync;
    assign o_face.de    = r_dly[2].de;
    assign o_face.data  = r_face;
endmodule

// File: tb/tb_skin_detect.sv
// Bench for skin_detect: a reference model compared on every cycle, plus
// directed skin/non-skin/boundary pixels with literal mask expectations.
module tb_skin_detect;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    skin_detect_if #(.DW(16)) src_if ();
    skin_detect_if #(.DW(16)) rgb_if ();
    skin_detect_if #(.DW(8))  face_if ();

    skin_detect #(
        .CB_MIN(8'd77), .CB_MAX(8'd127), .CR_MIN(8'd133), .CR_MAX(8'd173), .Y_MIN(8'd40)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .i_src (src_if),
        .o_rgb (rgb_if),
        .o_face(face_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        hs;
        logic        vs;
        logic        de;
        logic [15:0] d;
    } pix_t;

    pix_t  hist [3] = '{'{1'b0, 1'b0, 1'b0, 16'h0}, '{1'b0, 1'b0, 1'b0, 16'h0}, '{1'b0, 1'b0, 1'b0, 16'h0}};
    int    n_checks = 0;
    int    n_errors = 0;

    // Literal-check requests from the stimulus process, served by the compare process.
    int         lit_seq  = 0;
    int         lit_seen = 0;
    string      lit_name = "";
    int         lit_kind = 0;
    logic [7:0] lit_exp  = 8'h00;
    logic [7:0] lit_val  = 8'h00;

    function automatic void to_ycc(input logic [15:0] p, output int y, output int cb, output int cr);
        int r, g, b;
        r = int'(p[15:11]); r = r * 8 + r / 4;
        g = int'(p[10:5]);  g = g * 4 + g / 16;
        b = int'(p[4:0]);   b = b * 8 + b / 4;
        y  = (77 * r + 150 * g + 29 * b) / 256;
        cb = (32768 + 128 * b - 43 * r - 85 * g) / 256;
        cr = (32768 + 128 * r - 107 * g - 21 * b) / 256;
    endfunction

    function automatic logic [7:0] mask(input logic de, input logic [15:0] p);
        int y, cb, cr;
        if (!de) return 8'h00;
        to_ycc(p, y, cb, cr);
        return (y >= 40 && cb >= 77 && cb <= 127 && cr >= 133 && cr <= 173) ? 8'hff : 8'h00;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: output is the input three clocks ago; reset empties the pipe at once.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) hist[i] <= '{1'b0, 1'b0, 1'b0, 16'h0};
        end else begin
            hist[0] <= '{src_if.hsync, src_if.vsync, src_if.de, src_if.data};
            hist[1] <= hist[0];
            hist[2] <= hist[1];
        end
    end

    always begin
        @(negedge clk or negedge rst_n);
        #1;
        chk("rgb_bus", 32'({rgb_if.hsync, rgb_if.vsync, rgb_if.de, rgb_if.data}),
            32'({hist[2].hs, hist[2].vs, hist[2].de, hist[2].d}));
        chk("face_sync", 32'({face_if.hsync, face_if.vsync, face_if.de}),
            32'({hist[2].hs, hist[2].vs, hist[2].de}));
        chk("face_data", 32'(face_if.data), 32'(mask(hist[2].de, hist[2].d)));
        if (lit_seq != lit_seen) begin
            lit_seen = lit_seq;
            if (lit_kind == 0) chk(lit_name, 32'(face_if.data), 32'(lit_exp));
            else               chk(lit_name, 32'(lit_val), 32'(lit_exp));
        end
    end

    task automatic px(input logic hs, input logic vs, input logic de, input logic [15:0] d);
        @(posedge clk);
        #1;
        src_if.hsync = hs;
        src_if.vsync = vs;
        src_if.de    = de;
        src_if.data  = d;
    endtask

    task automatic lit_check(input string nm, input logic [15:0] d, input logic de, input logic [7:0] exp);
        px(1'b0, 1'b0, de, d);
        px(1'b0, 1'b0, 1'b0, 16'h0000);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        lit_name = nm;
        lit_kind = 0;
        lit_exp  = exp;
        lit_seq++;
    endtask

    task automatic val_check(input string nm, input logic [7:0] val, input logic [7:0] exp);
        @(negedge clk);
        lit_name = nm;
        lit_kind = 1;
        lit_val  = val;
        lit_exp  = exp;
        lit_seq++;
    endtask

    int          tgt_val   [8] = '{77, 127, 133, 173, 76, 128, 132, 174};
    logic [7:0]  tgt_exp   [8] = '{8'hff, 8'hff, 8'hff, 8'hff, 8'h00, 8'h00, 8'h00, 8'h00};
    logic        tgt_found [8];
    logic [15:0] tgt_pix   [8];

    initial begin
        int y, cb, cr;
        logic match;
        src_if.hsync = 1'b0;
        src_if.vsync = 1'b0;
        src_if.de    = 1'b0;
        src_if.data  = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        lit_check("skin_E510", 16'hE510, 1'b1, 8'hff);
        lit_check("red_F800", 16'hF800, 1'b1, 8'h00);
        lit_check("white_FFFF", 16'hFFFF, 1'b1, 8'h00);
        lit_check("black_0000", 16'h0000, 1'b1, 8'h00);
        lit_check("skin_de0", 16'hE510, 1'b0, 8'h00);

        // Boundary pixels: the targeted component sits exactly on (or one past) a bound.
        for (int t = 0; t < 8; t++) begin
            tgt_found[t] = 1'b0;
            tgt_pix[t]   = 16'h0;
        end
        for (int p = 0; p < 65536; p++) begin
            to_ycc(16'(p), y, cb, cr);
            for (int t = 0; t < 8; t++) begin
                if (t == 0 || t == 1 || t == 4 || t == 5)
                    match = (cb == tgt_val[t]) && cr >= 133 && cr <= 173;
                else
                    match = (cr == tgt_val[t]) && cb >= 77 && cb <= 127;
                if (!tgt_found[t] && match && y >= 40) begin
                    tgt_found[t] = 1'b1;
                    tgt_pix[t]   = 16'(p);
                end
            end
        end
        for (int t = 0; t < 8; t++) begin
            val_check($sformatf("bound_found_%0d", tgt_val[t]), {7'd0, tgt_found[t]}, 8'h01);
            if (tgt_found[t])
                lit_check($sformatf("bound_%0d", tgt_val[t]), tgt_pix[t], 1'b1, tgt_exp[t]);
        end

        // Small random frame with blanking; sync and data also move during blanking.
        for (int ln = 0; ln < 24; ln++) begin
            for (int c = 0; c < 56; c++) begin
                px((c >= 50 && c < 54), (ln < 2), (c < 48 && ln >= 2), 16'($urandom));
            end
        end

        // Reset asserted mid-line for two clocks, then released between edges.
        for (int c = 0; c < 40; c++) begin
            px((c >= 34), 1'b0, (c < 30), 16'($urandom));
            if (c == 12) begin
                @(negedge clk);
                #2 rst_n = 1'b0;
            end
            if (c == 14) begin
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
        end
        lit_check("post_reset_skin", 16'hE510, 1'b1, 8'hff);

        repeat (6) px(1'b0, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
